// File: rtl/mult_seq_pkg.sv
// Shared encodings for the multi-cycle multiplier: state codes, ready levels
// and start/stop request levels used by the ALU handshake.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    MULT_FREE = 2'b00,
    MULT_ON   = 2'b01,
    MULT_END  = 2'b10
  } mult_state_e;

  localparam logic MULT_RESULT_READY     = 1'b1;
  localparam logic MULT_RESULT_NOT_READY = 1'b0;
  localparam logic MULT_START            = 1'b1;
  localparam logic MULT_STOP             = 1'b0;

endpackage

// File: rtl/mult_addshift.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the high
// half and shift the whole product right, keeping the adder carry.
module mult_addshift #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  assign addend    = prod[0] ? {1'b0, mcand} : '0;
  assign sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
  assign prod_next = {sum, prod[WIDTH-1:1]};

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle signed/unsigned multiplier: shift-add on operand magnitudes for
// WIDTH cycles, then a sign fix-up; start/annul/ready handshake with the ALU.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_mult_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mult_state_e          state_reg;
  logic [CNT_W-1:0]     counter_reg;
  logic                 neg_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [2*WIDTH-1:0]   prod_next;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 ready_reg;

  // Two's-complement magnitude; the most negative value maps to its unsigned twin.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  mult_addshift #(.WIDTH(WIDTH)) u_addshift (
    .prod      (prod_reg),
    .mcand     (mcand_reg),
    .prod_next (prod_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= MULT_FREE;
      counter_reg <= '0;
      neg_reg     <= 1'b0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      result_reg  <= '0;
      ready_reg   <= MULT_RESULT_NOT_READY;
    end else begin
      case (state_reg)
        MULT_FREE: begin
          ready_reg  <= MULT_RESULT_NOT_READY;
          result_reg <= '0;
          if (start_i == MULT_START && !annul_i) begin
            neg_reg     <= signed_mult_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            mcand_reg   <= magnitude(opdata1_i, signed_mult_i);
            prod_reg    <= {{WIDTH{1'b0}}, magnitude(opdata2_i, signed_mult_i)};
            counter_reg <= '0;
            state_reg   <= MULT_ON;
          end
        end
        MULT_ON: begin
          if (annul_i) begin
            state_reg <= MULT_FREE;
          end else begin
            prod_reg    <= prod_next;
            counter_reg <= counter_reg + CNT_W'(1);
            if (counter_reg == LAST_ITER) begin
              state_reg <= MULT_END;
            end
          end
        end
        MULT_END: begin
          // Result is held for as long as the ALU keeps requesting.
          if (start_i == MULT_STOP || annul_i) begin
            state_reg  <= MULT_FREE;
            ready_reg  <= MULT_RESULT_NOT_READY;
            result_reg <= '0;
          end else begin
            ready_reg  <= MULT_RESULT_READY;
            result_reg <= neg_reg ? (~prod_reg + (2*WIDTH)'(1)) : prod_reg;
          end
        end
        default: begin
          state_reg  <= MULT_FREE;
          ready_reg  <= MULT_RESULT_NOT_READY;
          result_reg <= '0;
        end
      endcase
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle 32x32 signed/unsigned multiplier for the EX stage. It replaces the ALU's single-cycle combinational product for MULT/MULTU.
- It is driven by the ALU with the same start/annul/ready handshake the divider uses. Its 64-bit result goes to the ALU's hi_o/lo_o path.
- The ALU holds the pipeline stalled while the operation is in flight: stall = mult op & ~ready_o.
- The datapath is radix-2 shift-add on operand magnitudes, with a final sign fix-up.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH bits and the iteration count is WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_mult_i  input  1  1 = signed (MULT), 0 = unsigned (MULTU). Sampled only at start.
- opdata1_i  input  WIDTH  multiplicand (rs). Sampled only at start.
- opdata2_i  input  WIDTH  multiplier (rt). Sampled only at start.
- start_i  input  1  request an operation. Held high by the ALU until ready_o is seen.
- annul_i  input  1  abort the in-flight operation (exception/flush).
- result_o  output  2*WIDTH  product: {hi, lo}.
- ready_o  output  1  result_o is valid.

Behaviour:
- Reset: one clock is synchronous, and reset is synchronous and active-high. With rst=1 at a rising edge, the next state is state=IDLE, ready_o=0, result_o=0, counter=0 and all datapath registers are 0. Reset overrides every other input, including reset in the middle of an operation (ON or END).
- States: IDLE, ON, END. All outputs are registered.
- IDLE:
  - If start_i=1 and annul_i=0: latch neg = signed_mult_i & (opdata1_i[MSB] ^ opdata2_i[MSB]).
  - Latch mcand = |opdata1_i| and mplr = |opdata2_i|. Magnitude is two's-complement negation, applied only when signed and MSB=1. 0x80000000 maps to unsigned 0x80000000.
  - Load prod = {0, mplr}, counter = 0, then go to ON.
  - Otherwise stay in IDLE with ready_o=0 and result_o=0.
- ON: one iteration per cycle.
  - sum = prod[2W-1:W] + (prod[0] ? mcand : 0), computed as a (W+1)-bit sum.
  - prod = {sum, prod[W-1:1]}, i.e. a right shift that keeps the carry.
  - counter increments. After the iteration with counter = W-1, go to END.
  - If annul_i=1 in any ON cycle: go to IDLE, the iteration is discarded, and ready_o stays 0.
- END:
  - result_o = neg ? (~prod + 1) : prod, and ready_o = 1.
  - Both are held while start_i=1.
  - When start_i=0: go to IDLE with ready_o=0 and result_o=0 on the following edge.
  - annul_i in END has the same effect as start_i=0.
- Latency: start_i is sampled at edge E0, and ready_o rises at edge E0+W+1 (E33 for W=32). Latency is fixed and independent of the operand values; there is no zero fast path.
- Operand changes after E0 are ignored.
- start_i and annul_i both high in IDLE: no start.
- start_i staying high after END→IDLE (i.e. a new request) starts a fresh operation from IDLE.
- Widths: the adder is W+1 bits wide, so its carry is never lost. The final negation is 2W bits, so 0x80000000*0x80000000 signed gives 0x4000000000000000.

Decomposition:
- Shared defines header (alongside the ALU control codes): MULT_FREE/MULT_ON/MULT_END state encodings (2 bits), MULT_RESULT_READY / MULT_RESULT_NOT_READY, and MULT_START / MULT_STOP.
- One natural sub-module: mult_addshift, the combinational (W+1)-bit add and shift step. The state machine stays in mult_seq.

Test Plan:
- Unsigned 3 x 5, start held until ready → ready_o rises exactly 33 edges after start is sampled; result_o=0x000000000000000F. Drop start → one edge later ready_o=0 and result_o=0.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE00000001. Signed on the same operands (-1 x -1) → 0x0000000000000001.
- Signed 0xFFFFFFFD x 0x00000005 → 0xFFFFFFFFFFFFFFF1. Signed 0x80000000 x 0x80000000 → 0x4000000000000000.
- Change opdata1_i/opdata2_i every cycle after start is sampled with 7 x 9 → result still 0x3F.
- annul_i pulsed at iteration 10 → IDLE next edge, ready_o never asserts. A new start 2 x 2 → 0x4 after 33 edges.
- rst pulsed during ON and again during END → outputs 0 and state IDLE on the next edge. start_i+annul_i both high in IDLE → no operation, ready_o stays 0.
